r30_entropy_sampler: RTL and testbench

Sequential consumer of the Rule 30 cellular automaton. It holds an N-bit cyclic CA state register and advances it by one Rule 30 generation per active cycle. It taps the centre cell each generation and packs the bits into W-bit words, which it hands downstream over a valid/ready interface. It sits between seed provisioning and any block that consumes random words (nonce or ID generation).

---
 rtl/r30_entropy_sampler_if.sv | 25 ++
 rtl/r30_entropy_sampler.sv | 110 +++++++++++
 tb/tb_r30_entropy_sampler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/r30_entropy_sampler_if.sv
// Seed/output bundle of the Rule 30 entropy sampler.
// The master side provides seeds and consumes words. The slave side is the sampler.
interface r30_entropy_sampler_if #(
  parameter int N = 128,
  parameter int W = 8
);
  logic [N-1:0] seed_in;
  logic         seed_load;
  logic         seed_err;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] state_q;
  logic [15:0]  word_cnt;

  modport master (
    output seed_in, seed_load, out_ready,
    input  seed_err, out_data, out_valid, state_q, word_cnt
  );

  modport slave (
    input  seed_in, seed_load, out_ready,
    output seed_err, out_data, out_valid, state_q, word_cnt
  );
endinterface

// File: rtl/r30_entropy_sampler.sv
// Rule 30 entropy sampler.
// A cyclic N-cell Rule 30 CA advances one generation per FILL cycle.
// The centre cell of each generation is packed MSB-first into W-bit words.
// Each word is offered over a valid/ready handshake.
module r30_entropy_sampler #(
  parameter int N      = 128,
  parameter int W      = 8,
  parameter int CENTER = N / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  r30_entropy_sampler_if.slave   bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD
  } fsm_t;

  fsm_t          r_fsm;
  logic [N-1:0]  r_ca;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic          r_seed_err;
  logic [CW-1:0] r_bit_cnt;
  logic [15:0]   r_word_cnt;

  logic [N-1:0]  w_left;
  logic [N-1:0]  w_right;
  logic [N-1:0]  w_ca_next;
  logic [W-1:0]  w_acc_next;
  logic          w_seed_zero;
  logic          w_last_bit;

  // Rule 30 neighbourhood with cyclic wrap.
  // w_left[i] = s[i+1] and w_right[i] = s[i-1].
  assign w_left      = {r_ca[0], r_ca[N-1:1]};
  assign w_right     = {r_ca[N-2:0], r_ca[N-1]};
  assign w_ca_next   = w_left ^ (r_ca | w_right);
  assign w_acc_next  = (r_acc << 1) | W'(r_ca[CENTER]);
  assign w_seed_zero = (bus.seed_in == '0);
  assign w_last_bit  = (r_bit_cnt == CW'(W - 1));

  // Single FSM process.
  // All outputs are registered, so out_ready never reaches out_valid combinationally.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here. All state, including the CA register, clears on the
    // sampled edge. Non-blocking assignments keep every register reading pre-edge values.
    if (!rst_n) begin
      r_fsm       <= ST_IDLE;
      r_ca        <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_seed_err  <= 1'b0;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_seed_err <= 1'b0;
      if (bus.seed_load) begin
        // A load overrides everything, including a word held in HOLD, which is dropped uncounted.
        r_out_valid <= 1'b0;
        r_bit_cnt   <= '0;
        r_acc       <= '0;
        if (w_seed_zero) begin
          // An all-zero state is a fixed point of Rule 30, so the seed is refused.
          r_fsm      <= ST_IDLE;
          r_seed_err <= 1'b1;
        end else begin
          r_ca  <= bus.seed_in;
          r_fsm <= ST_FILL;
        end
      end else begin
        case (r_fsm)
          ST_IDLE: ;
          ST_FILL: begin
            r_acc     <= w_acc_next;
            r_ca      <= w_ca_next;
            r_bit_cnt <= r_bit_cnt + CW'(1);
            if (w_last_bit) begin
              r_out_data  <= w_acc_next;
              r_out_valid <= 1'b1;
              r_fsm       <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (r_out_valid && bus.out_ready) begin
              r_word_cnt  <= r_word_cnt + 16'd1;
              r_bit_cnt   <= '0;
              r_out_valid <= 1'b0;
              r_fsm       <= ST_FILL;
            end
          end
          default: r_fsm <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.seed_err  = r_seed_err;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.state_q   = r_ca;
  assign bus.word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_r30_entropy_sampler.sv
// Self-checking bench for r30_entropy_sampler (N=128, W=8).
// A reference Rule 30 model fills a scoreboard queue with expected words whenever a seed is loaded.
// Each new word presented by the DUT is popped from that queue and compared.
module tb_r30_entropy_sampler;

  localparam int N      = 128;
  localparam int W      = 8;
  localparam int CENTER = N / 2;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_state;
  logic         prev_valid = 1'b0;
  logic [N-1:0] golden;
  logic [N-1:0] snap;
  logic [15:0]  cnt_before;
  int           n;

  r30_entropy_sampler_if #(.N(N), .W(W)) bus ();

  r30_entropy_sampler #(.N(N), .W(W), .CENTER(CENTER)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference Rule 30 step with cyclic boundary, written straight from the rule.
  function automatic logic [N-1:0] rule30(input logic [N-1:0] s);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = s[(i + 1) % N] ^ (s[i] | s[(i + N - 1) % N]);
    return r;
  endfunction

  task automatic push_next();
    logic [W-1:0] w;
    w = '0;
    for (int b = 0; b < W; b++) begin
      w       = (w << 1) | W'(m_state[CENTER]);
      m_state = rule30(m_state);
    end
    exp_q.push_back(w);
  endtask

  // Advance to the next falling edge.
  // Score any word newly presented by the DUT.
  task automatic tick();
    logic [W-1:0] w;
    @(negedge clk);
    if (bus.out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", bus.out_data, 'x);
      end else begin
        w = exp_q.pop_front();
        check("sb_word", bus.out_data, w);
        push_next();
      end
    end
    prev_valid = bus.out_valid;
  endtask

  task automatic load(input logic [N-1:0] s);
    bus.seed_in   = s;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    exp_q.delete();
    if (s != '0) begin
      m_state = s;
      repeat (3) push_next();
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.seed_load = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 64) begin
      tick();
      cnt++;
    end
    if (!bus.out_valid) check("valid_timeout", 0, 1);
  endtask

  initial begin
    golden         = '0;
    golden[64]     = 1'b1;
    bus.seed_in    = '0;
    bus.seed_load  = 1'b0;
    bus.out_ready  = 1'b0;
    rst_n          = 1'b0;

    // Reset, then idle with no load.
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_data", bus.out_data, 0);
    check("rst_err", bus.seed_err, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", bus.out_valid, 0);
      check("idle_state", bus.state_q, 0);
      check("idle_cnt", bus.word_cnt, 0);
    end

    // Golden stream with out_ready held high.
    bus.out_ready = 1'b1;
    load(golden);
    check("load_state", bus.state_q, golden);
    tick();
    snap = '0; snap[63] = 1'b1; snap[64] = 1'b1; snap[65] = 1'b1;
    check("first_step_state", bus.state_q, snap);
    wait_valid(n);
    check("first_latency", n + 1, W);
    check("golden_w0", bus.out_data, 8'hDC);
    tick();
    check("valid_pulse_1cyc", bus.out_valid, 0);
    check("cnt_after_w0", bus.word_cnt, 1);
    wait_valid(n);
    check("word_period", n + 1, W + 1);
    check("golden_w1", bus.out_data, 8'hC5);

    // Wrap-around across index 0 / N-1.
    do_reset();
    snap = '0; snap[N-1] = 1'b1;
    load(snap);
    tick();
    snap = '0; snap[N-1] = 1'b1; snap[N-2] = 1'b1; snap[0] = 1'b1;
    check("wrap_state", bus.state_q, snap);

    // Backpressure: word and state freeze while out_ready is low.
    do_reset();
    bus.out_ready = 1'b0;
    load(golden);
    wait_valid(n);
    check("bp_latency", n, W);
    snap = bus.state_q;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_data", bus.out_data, 8'hDC);
      check("bp_state", bus.state_q, snap);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_cnt", bus.word_cnt, 1);
    check("bp_valid_drop", bus.out_valid, 0);
    wait_valid(n);
    check("bp_w1", bus.out_data, 8'hC5);

    // Zero seed while holding a word.
    cnt_before = bus.word_cnt;
    snap       = bus.state_q;
    load('0);
    check("zero_err_pulse", bus.seed_err, 1);
    check("zero_valid", bus.out_valid, 0);
    check("zero_cnt", bus.word_cnt, cnt_before);
    check("zero_state", bus.state_q, snap);
    tick();
    check("zero_err_clear", bus.seed_err, 0);
    repeat (10) tick();
    check("zero_no_step", bus.state_q, snap);
    check("zero_idle_valid", bus.out_valid, 0);

    // Reload at the 4th FILL cycle restarts the stream.
    bus.out_ready = 1'b1;
    load(golden);
    repeat (3) tick();
    load(golden);
    check("reload_state", bus.state_q, golden);
    wait_valid(n);
    check("reload_latency", n, W);
    check("reload_w0", bus.out_data, 8'hDC);

    // A load beats a simultaneous handshake in HOLD.
    cnt_before = bus.word_cnt;
    load(golden);
    check("load_vs_hs_cnt", bus.word_cnt, cnt_before);
    check("load_vs_hs_valid", bus.out_valid, 0);
    wait_valid(n);
    check("load_vs_hs_w0", bus.out_data, 8'hDC);
    tick();

    // Reset asserted at the 5th FILL bit.
    load(golden);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data", bus.out_data, 0);
    check("midrst_state", bus.state_q, 0);
    check("midrst_cnt", bus.word_cnt, 0);
    check("midrst_err", bus.seed_err, 0);
    load(golden);
    wait_valid(n);
    check("midrst_w0", bus.out_data, 8'hDC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
